// File: rtl/sprite_pkg.sv
// Shared constants, table entry payload and scheduler state encoding for sprite_draw_scheduler.
package sprite_pkg;

  localparam int unsigned MAX_SPRITES   = 16;
  localparam int unsigned CANVAS_WIDTH  = 360;
  localparam int unsigned CANVAS_HEIGHT = 720;
  localparam int unsigned NUM_FRAMES    = 18;
  localparam int unsigned FCW           = 6;

  localparam int unsigned IW = $clog2(MAX_SPRITES);
  localparam int unsigned XW = $clog2(CANVAS_WIDTH);
  localparam int unsigned YW = $clog2(CANVAS_HEIGHT);
  localparam int unsigned FW = $clog2(NUM_FRAMES);
  localparam int unsigned CW = IW + 1;

  typedef struct packed {
    logic          valid;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [FW-1:0] frame;
  } sprite_entry_t;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    ISSUE,
    HOLD,
    WAIT,
    DONE
  } sched_state_t;

endpackage

// File: rtl/sprite_draw_scheduler_table.sv
// Sprite entry storage: one synchronous write port, one combinational read port.
module sprite_draw_scheduler_table
  import sprite_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  sprite_entry_t wdata,
  input  logic [IW-1:0] raddr,
  output sprite_entry_t rdata_c
);

  sprite_entry_t mem_q [MAX_SPRITES];

  // Entry write; reset clears every entry including its valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(MAX_SPRITES); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata_c = mem_q[raddr];

endmodule

// File: rtl/sprite_draw_scheduler.sv
// Walks the sprite table once per frame and hands valid entries to the renderer.
// Optional overrun counters are built when SPRITE_SCHED_OVERRUN_EN is defined.
module sprite_draw_scheduler
  import sprite_pkg::*;
(
  input  logic           clk_pixel,
  input  logic           sys_rst_n,
  input  logic [FCW-1:0] frame_count,
  input  logic           tbl_we,
  input  logic [IW-1:0]  tbl_addr,
  input  logic           tbl_valid,
  input  logic [XW-1:0]  tbl_x,
  input  logic [YW-1:0]  tbl_y,
  input  logic [FW-1:0]  tbl_frame,
  input  logic           gfx_ready,
  output logic           sprite_valid,
  output logic [XW-1:0]  sprite_x,
  output logic [YW-1:0]  sprite_y,
  output logic [FW-1:0]  sprite_frame_number,
  output logic           busy,
  output logic           pass_done,
  output logic [CW-1:0]  sprites_drawn
`ifdef SPRITE_SCHED_OVERRUN_EN
  ,
  output logic [7:0]     overrun_count,
  output logic           overrun_flag
`endif
);

  localparam logic [IW-1:0] LAST_IDX = IW'(MAX_SPRITES - 1);

  sched_state_t   state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [FCW-1:0] prev_fc_q;
  logic           restart_q, restart_d;
  logic           busy_q, busy_d;
  logic           pass_done_q, pass_done_d;
  logic           sprite_valid_q, sprite_valid_d;
  logic [XW-1:0]  sprite_x_q, sprite_x_d;
  logic [YW-1:0]  sprite_y_q, sprite_y_d;
  logic [FW-1:0]  sprite_frame_q, sprite_frame_d;
  logic [CW-1:0]  drawn_q, drawn_d;
  logic           new_frame_c;
  sprite_entry_t  wr_entry_c;
  sprite_entry_t  rd_entry_c;

  assign new_frame_c = (frame_count != prev_fc_q);
  assign wr_entry_c  = '{valid: tbl_valid, x: tbl_x, y: tbl_y, frame: tbl_frame};

  sprite_draw_scheduler_table u_table (
    .clk     (clk_pixel),
    .rst_n   (sys_rst_n),
    .we      (tbl_we),
    .waddr   (tbl_addr),
    .wdata   (wr_entry_c),
    .raddr   (idx_q),
    .rdata_c (rd_entry_c)
  );

  // Pass sequencing: scan, issue, hold, wait for renderer, finish or restart on overrun.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    cnt_d          = cnt_q;
    restart_d      = restart_q;
    busy_d         = busy_q;
    pass_done_d    = 1'b0;
    sprite_valid_d = 1'b0;
    sprite_x_d     = sprite_x_q;
    sprite_y_d     = sprite_y_q;
    sprite_frame_d = sprite_frame_q;
    drawn_d        = drawn_q;
    case (state_q)
      IDLE: begin
        if (new_frame_c) begin
          idx_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (new_frame_c) begin
          idx_d = '0;
          cnt_d = '0;
        end else if (rd_entry_c.valid) begin
          sprite_x_d     = rd_entry_c.x;
          sprite_y_d     = rd_entry_c.y;
          sprite_frame_d = rd_entry_c.frame;
          state_d        = ISSUE;
        end else if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      ISSUE: begin
        if (new_frame_c) begin
          idx_d   = '0;
          cnt_d   = '0;
          state_d = SCAN;
        end else if (gfx_ready) begin
          sprite_valid_d = 1'b1;
          cnt_d          = cnt_q + CW'(1);
          state_d        = HOLD;
        end
      end
      HOLD: begin
        // Renderer drops ready one cycle after accepting, so ready is not sampled here.
        if (new_frame_c) begin
          restart_d = 1'b1;
        end
        state_d = WAIT;
      end
      WAIT: begin
        if (new_frame_c) begin
          restart_d = 1'b1;
        end
        if (gfx_ready) begin
          if (restart_q || new_frame_c) begin
            idx_d     = '0;
            cnt_d     = '0;
            restart_d = 1'b0;
            state_d   = SCAN;
          end else if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = SCAN;
          end
        end
      end
      DONE: begin
        pass_done_d = 1'b1;
        drawn_d     = cnt_q;
        if (new_frame_c) begin
          idx_d   = '0;
          cnt_d   = '0;
          state_d = SCAN;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Scheduler state and registered outputs.
  always_ff @(posedge clk_pixel or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      cnt_q          <= '0;
      prev_fc_q      <= '0;
      restart_q      <= 1'b0;
      busy_q         <= 1'b0;
      pass_done_q    <= 1'b0;
      sprite_valid_q <= 1'b0;
      sprite_x_q     <= '0;
      sprite_y_q     <= '0;
      sprite_frame_q <= '0;
      drawn_q        <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      cnt_q          <= cnt_d;
      prev_fc_q      <= frame_count;
      restart_q      <= restart_d;
      busy_q         <= busy_d;
      pass_done_q    <= pass_done_d;
      sprite_valid_q <= sprite_valid_d;
      sprite_x_q     <= sprite_x_d;
      sprite_y_q     <= sprite_y_d;
      sprite_frame_q <= sprite_frame_d;
      drawn_q        <= drawn_d;
    end
  end

  assign sprite_valid        = sprite_valid_q;
  assign sprite_x            = sprite_x_q;
  assign sprite_y            = sprite_y_q;
  assign sprite_frame_number = sprite_frame_q;
  assign busy                = busy_q;
  assign pass_done           = pass_done_q;
  assign sprites_drawn       = drawn_q;

`ifdef SPRITE_SCHED_OVERRUN_EN
  logic       abandon_c;
  logic [7:0] ov_cnt_q, ov_cnt_d;
  logic       ov_flag_q, ov_flag_d;

  // A pass is abandoned once per overrun; a restart already pending is not recounted.
  always_comb begin
    abandon_c = new_frame_c &&
                ((state_q == SCAN) || (state_q == ISSUE) ||
                 (((state_q == HOLD) || (state_q == WAIT)) && !restart_q));
    ov_cnt_d  = ov_cnt_q;
    ov_flag_d = ov_flag_q;
    if (abandon_c) begin
      ov_flag_d = 1'b1;
      if (ov_cnt_q != 8'hFF) begin
        ov_cnt_d = ov_cnt_q + 8'd1;
      end
    end
  end

  // Overrun statistics registers.
  always_ff @(posedge clk_pixel or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ov_cnt_q  <= '0;
      ov_flag_q <= 1'b0;
    end else begin
      ov_cnt_q  <= ov_cnt_d;
      ov_flag_q <= ov_flag_d;
    end
  end

  assign overrun_count = ov_cnt_q;
  assign overrun_flag  = ov_flag_q;
`endif

endmodule
